// File: rtl/axi_datamover_write.sv
// axi_datamover_write: S2MM DataMover client issuing one command, streaming user beats, and consuming status.
module axi_datamover_write #(
  parameter int DATA_WIDTH = 64,
  parameter int CMD_WIDTH  = 72,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int STS_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [LEN_WIDTH-1:0]    wdata_len,
  output logic                    busy,
  output logic                    wready,
  input  logic                    wdata_vld,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    done,
  output logic                    err,
  output logic [STS_WIDTH-1:0]    sts_code,
  output logic [CMD_WIDTH-1:0]    s2mm_cmd_tdata,
  output logic                    s2mm_cmd_tvalid,
  input  logic                    s2mm_cmd_tready,
  output logic [DATA_WIDTH-1:0]   s2mm_tdata,
  output logic [DATA_WIDTH/8-1:0] s2mm_tkeep,
  output logic                    s2mm_tlast,
  output logic                    s2mm_tvalid,
  input  logic                    s2mm_tready,
  input  logic [STS_WIDTH-1:0]    s2mm_sts_tdata,
  input  logic [STS_WIDTH/8-1:0]  s2mm_sts_tkeep,
  input  logic                    s2mm_sts_tlast,
  output logic                    s2mm_sts_tready,
  input  logic                    s2mm_sts_tvalid
);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, CMD, DATA, STS} state_t;
  state_t state, state_n;
  logic [3:0] tag;
  logic [LEN_WIDTH-1:0] remaining, rem, beats;
  logic [KW-1:0] last_keep;
  logic accept, cmd_hs, beat_hs, sts_hs, in_data, last;
  logic unused_sts;
  assign unused_sts = ^{s2mm_sts_tkeep, s2mm_sts_tlast};
  // rem/beats via mask and shift; KW is a power of two
  assign rem     = wdata_len & LEN_WIDTH'(KW - 1);
  assign beats   = (wdata_len >> $clog2(KW)) + LEN_WIDTH'(rem != '0);
  assign accept  = state == IDLE && start && wdata_len != '0;
  assign cmd_hs  = state == CMD && s2mm_cmd_tready;
  assign beat_hs = s2mm_tvalid && s2mm_tready;
  assign sts_hs  = state == STS && s2mm_sts_tvalid;
  assign in_data = state == DATA;
  assign last    = remaining == LEN_WIDTH'(1);
  assign busy            = state != IDLE;
  assign s2mm_cmd_tvalid = state == CMD;
  assign s2mm_sts_tready = state == STS;
  assign s2mm_tvalid     = in_data && wdata_vld;
  assign wready          = in_data && s2mm_tready;
  assign s2mm_tlast      = in_data && last;
  assign s2mm_tdata      = in_data ? wdata : '0;
  assign s2mm_tkeep      = !in_data ? '0 : last ? last_keep : '1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? CMD : IDLE;
      CMD:     state_n = cmd_hs ? DATA : CMD;
      DATA:    state_n = beat_hs && last ? STS : DATA;
      default: state_n = sts_hs ? IDLE : STS;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      tag            <= '0;
      remaining      <= '0;
      last_keep      <= '0;
      s2mm_cmd_tdata <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      sts_code       <= '0;
    end else begin
      state <= state_n;
      done  <= sts_hs;
      if (accept) begin
        s2mm_cmd_tdata <= {4'h0, tag, waddr, 1'b0, 1'b1, 6'h0, 1'b1, 23'(wdata_len)};
        remaining      <= beats;
        last_keep      <= rem == '0 ? '1 : ~({KW{1'b1}} << rem);
      end
      if (cmd_hs) tag <= tag + 4'd1;
      if (beat_hs) remaining <= remaining - LEN_WIDTH'(1);
      if (sts_hs) begin
        sts_code <= s2mm_sts_tdata;
        err      <= ~s2mm_sts_tdata[7] | s2mm_sts_tdata[6] | s2mm_sts_tdata[5] | s2mm_sts_tdata[4] |
                    (s2mm_sts_tdata[3:0] != s2mm_cmd_tdata[CMD_WIDTH-5 -: 4]);
      end
    end
  end
endmodule

// File: tb/tb_axi_datamover_write.sv
// tb_axi_datamover_write: directed checks of command, beat, status and reset behaviour.
module tb_axi_datamover_write;
  logic clk = 0, rstn = 0, start = 0, wdata_vld = 0;
  logic [31:0] waddr = 0;
  logic [15:0] wdata_len = 0;
  logic [63:0] wdata = 0;
  logic busy, wready, done, err, s2mm_cmd_tvalid, s2mm_tlast, s2mm_tvalid, s2mm_sts_tready;
  logic [7:0] sts_code, s2mm_tkeep;
  logic [71:0] s2mm_cmd_tdata;
  logic [63:0] s2mm_tdata;
  logic s2mm_cmd_tready = 0, s2mm_tready = 0, s2mm_sts_tvalid = 0;
  logic [7:0] s2mm_sts_tdata = 0;
  int checks = 0, errors = 0;

  axi_datamover_write dut (
    .clk(clk), .rstn(rstn), .start(start), .waddr(waddr), .wdata_len(wdata_len),
    .busy(busy), .wready(wready), .wdata_vld(wdata_vld), .wdata(wdata),
    .done(done), .err(err), .sts_code(sts_code),
    .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready),
    .s2mm_tdata(s2mm_tdata), .s2mm_tkeep(s2mm_tkeep), .s2mm_tlast(s2mm_tlast),
    .s2mm_tvalid(s2mm_tvalid), .s2mm_tready(s2mm_tready),
    .s2mm_sts_tdata(s2mm_sts_tdata), .s2mm_sts_tkeep(1'b1), .s2mm_sts_tlast(1'b1),
    .s2mm_sts_tready(s2mm_sts_tready), .s2mm_sts_tvalid(s2mm_sts_tvalid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] cmdw(input logic [3:0] t, input logic [31:0] a, input logic [15:0] l);
    return {4'h0, t, a, 1'b0, 1'b1, 6'h0, 1'b1, 7'h0, l};
  endfunction

  function automatic logic [63:0] bt(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  task automatic idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmdv"}, s2mm_cmd_tvalid, 0);
    chk({tag, "_tvalid"}, s2mm_tvalid, 0);
    chk({tag, "_tkeep"}, s2mm_tkeep, 0);
    chk({tag, "_tlast"}, s2mm_tlast, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_stsr"}, s2mm_sts_tready, 0);
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [15:0] len, input logic [7:0] sts,
                      input logic [3:0] tag, input logic exp_err, input int nb, input logic [7:0] lk,
                      input bit poke);
    start = 1; waddr = addr; wdata_len = len;
    tick;
    start = 0;
    chk("cmd_busy", busy, 1);
    chk("cmd_valid", s2mm_cmd_tvalid, 1);
    chk("cmd_word", s2mm_cmd_tdata, cmdw(tag, addr, len));
    s2mm_cmd_tready = 1;
    tick;
    s2mm_cmd_tready = 0;
    chk("cmd_drop", s2mm_cmd_tvalid, 0);
    for (int i = 0; i < nb; i++) begin
      wdata = bt(i); wdata_vld = 1; s2mm_tready = 1;
      if (poke && i == 0) begin start = 1; waddr = 32'hDEAD_0000; wdata_len = 16'd16; end
      #1;
      chk("beat_valid", s2mm_tvalid, 1);
      chk("beat_wready", wready, 1);
      chk("beat_data", s2mm_tdata, bt(i));
      chk("beat_keep", s2mm_tkeep, i == nb - 1 ? lk : 8'hFF);
      chk("beat_last", s2mm_tlast, i == nb - 1);
      tick;
      start = 0;
      if (poke) chk("poke_cmdv", s2mm_cmd_tvalid, 0);
    end
    wdata_vld = 0; s2mm_tready = 0;
    chk("sts_ready", s2mm_sts_tready, 1);
    chk("sts_busy", busy, 1);
    s2mm_sts_tvalid = 1; s2mm_sts_tdata = sts;
    tick;
    s2mm_sts_tvalid = 0;
    chk("done", done, 1);
    chk("err", err, exp_err);
    chk("done_busy", busy, 0);
    chk("sts_code", sts_code, sts);
    tick;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [7:0] vpat, rpat;
    int got;
    vpat = 8'b1011_0110;
    rpat = 8'b0110_1101;
    tick; tick;
    idle_zero("rst");
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sts", sts_code, 0);
    chk("rst_cmd", s2mm_cmd_tdata, 0);
    rstn = 1;
    tick;
    xfer(32'h1000, 16'd32, 8'h80, 4'd0, 0, 4, 8'hFF, 0);
    xfer(32'h2000, 16'd20, 8'h81, 4'd1, 0, 3, 8'h0F, 0);
    // backpressure on command and data paths
    start = 1; waddr = 32'h3000; wdata_len = 16'd32;
    tick;
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmdv", s2mm_cmd_tvalid, 1);
      chk("bp_cmd", s2mm_cmd_tdata, cmdw(4'd2, 32'h3000, 16'd32));
      tick;
    end
    s2mm_cmd_tready = 1;
    tick;
    s2mm_cmd_tready = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      wdata_vld = vpat[c % 8]; s2mm_tready = rpat[c % 8]; wdata = bt(got);
      #1;
      chk("bp_wready", wready, rpat[c % 8]);
      if (wdata_vld && s2mm_tready) begin
        chk("bp_data", s2mm_tdata, bt(got));
        chk("bp_last", s2mm_tlast, got == 3);
        got++;
      end
      tick;
    end
    wdata_vld = 0; s2mm_tready = 0;
    chk("bp_beats", got, 4);
    chk("bp_sts_ready", s2mm_sts_tready, 1);
    s2mm_sts_tvalid = 1; s2mm_sts_tdata = 8'h82;
    tick;
    s2mm_sts_tvalid = 0;
    chk("bp_done", done, 1);
    chk("bp_err", err, 0);
    tick;
    xfer(32'h4000, 16'd8, 8'hC3, 4'd3, 1, 1, 8'hFF, 0);
    xfer(32'h4100, 16'd8, 8'h82, 4'd4, 1, 1, 8'hFF, 0);
    // zero-length start is ignored
    start = 1; waddr = 32'h5000; wdata_len = 0;
    tick;
    start = 0;
    idle_zero("len0");
    tick;
    chk("len0_done", done, 0);
    xfer(32'h6000, 16'd16, 8'h85, 4'd5, 0, 2, 8'hFF, 1);
    xfer(32'h6100, 16'd13, 8'h86, 4'd6, 0, 2, 8'h1F, 0);
    // reset in the middle of data
    start = 1; waddr = 32'h7000; wdata_len = 16'd32;
    tick;
    start = 0; s2mm_cmd_tready = 1;
    tick;
    s2mm_cmd_tready = 0; wdata_vld = 1; s2mm_tready = 1;
    tick; tick;
    #1 rstn = 0;
    #1;
    idle_zero("mid");
    chk("mid_cmd", s2mm_cmd_tdata, 0);
    chk("mid_done", done, 0);
    wdata_vld = 0; s2mm_tready = 0;
    #1 rstn = 1;
    tick;
    chk("mid_done2", done, 0);
    xfer(32'h8000, 16'd8, 8'h80, 4'd0, 0, 1, 8'hFF, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
